// File: rtl/wave_pkg.sv
// Shared constants and the sample scaling helper for the waveform display path.
package wave_pkg;

    localparam logic [1:0]  REGION_X_SEL     = 2'b01;
    localparam int          SAMPLE_W         = 8;
    localparam int          ADDR_W           = 9;
    localparam int          SAMPLES_PER_HALF = 256;
    localparam int          IDX_W            = $clog2(SAMPLES_PER_HALF);
    localparam logic [7:0]  DEFAULT_Y_OFFSET = 8'd32;
    localparam logic [23:0] GRID_COLOR       = 24'h404040;

    // Halve the raw sample so 256 codes fit 128 double-height rows, then shift down.
    function automatic logic [SAMPLE_W-1:0] scale_sample(
        input logic [SAMPLE_W-2:0] half_val,
        input logic [SAMPLE_W-1:0] offset
    );
        return {1'b0, half_val} + offset;
    endfunction

endpackage

// File: rtl/wave_display_if.sv
// Scan-position, sample-RAM read port and pixel output bundle of the waveform display.
interface wave_display_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    import wave_pkg::*;

    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic                valid;
    logic                read_index;
    logic [SAMPLE_W-1:0] read_value;
    logic [ADDR_W-1:0]   read_address;
    logic                wave_display_idle;
    logic                valid_pixel;
    logic [7:0]          r;
    logic [7:0]          g;
    logic [7:0]          b;

    modport master (
        output x, y, valid, read_index, read_value,
        input  read_address, wave_display_idle, valid_pixel, r, g, b
    );

    modport slave (
        input  x, y, valid, read_index, read_value,
        output read_address, wave_display_idle, valid_pixel, r, g, b
    );

endinterface

// File: rtl/wave_pipe_delay.sv
// Reset-to-zero delay line of configurable width and depth.
module wave_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/wave_display.sv
// Reads the displayed RAM half along the scan and draws the stored samples as a
// connected trace in the upper-right window. Optional grid overlay: WAVE_DISPLAY_GRID_EN.
module wave_display
    import wave_pkg::*;
#(
    parameter int                  X_W         = 11,
    parameter int                  Y_W         = 10,
    parameter logic [SAMPLE_W-1:0] Y_OFFSET    = DEFAULT_Y_OFFSET,
    parameter logic [23:0]         TRACE_COLOR = 24'hFFFFFF
) (
    input  logic          clk,
    input  logic          reset,
    wave_display_if.slave bus
);

    logic                r_frame_index;
    logic                r_idle;
    logic                r_valid_pixel;
    logic [23:0]         r_rgb;
    logic [SAMPLE_W-1:0] r_prev_val;
    logic [SAMPLE_W-1:0] r_cur_val;
    logic [IDX_W-1:0]    r_held_addr;

    logic                w_in_region;
    logic                w_frame_start;
    logic [Y_W-1:0]      w_y1;
    logic                w_valid1;
    logic                w_region1;
    logic [IDX_W-1:0]    w_addr1;
    logic [Y_W-1:0]      w_y2;
    logic                w_valid2;
    logic                w_region2;
    logic [SAMPLE_W-1:0] w_scaled;
    logic                w_new_sample;
    logic [SAMPLE_W-1:0] w_lo;
    logic [SAMPLE_W-1:0] w_hi;
    logic [SAMPLE_W-1:0] w_row;
    logic                w_hit;
    logic [23:0]         w_rgb_next;
    logic                w_unused;

    assign w_in_region   = bus.valid
                         & (bus.x[X_W-1 -: 2] == REGION_X_SEL)
                         & ~bus.y[Y_W-1];
    assign w_frame_start = bus.valid & (bus.x == '0) & (bus.y == '0);

    // Address uses the frame-locked half so a mid-frame swap never tears the trace.
    assign bus.read_address = {r_frame_index, bus.x[IDX_W:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_index <= 1'b0;
        end else if (w_frame_start) begin
            r_frame_index <= bus.read_index;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= 1'b0;
        end else begin
            r_idle <= ~w_in_region;
        end
    end

    wave_pipe_delay #(
        .WIDTH (Y_W + 2 + IDX_W),
        .DEPTH (1)
    ) u_stage1 (
        .clk   (clk),
        .reset (reset),
        .i_d   ({bus.y, bus.valid, w_in_region, bus.x[IDX_W:1]}),
        .o_q   ({w_y1, w_valid1, w_region1, w_addr1})
    );

    wave_pipe_delay #(
        .WIDTH (Y_W + 2),
        .DEPTH (1)
    ) u_stage2 (
        .clk   (clk),
        .reset (reset),
        .i_d   ({w_y1, w_valid1, w_region1}),
        .o_q   ({w_y2, w_valid2, w_region2})
    );

    assign w_scaled     = scale_sample(bus.read_value[SAMPLE_W-1:1], Y_OFFSET);
    assign w_new_sample = w_region1 & ((w_addr1 != r_held_addr) | ~w_region2);

    // Sample 0 seeds prev with itself so no segment joins the previous row's last sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_val  <= '0;
            r_cur_val   <= '0;
            r_held_addr <= '0;
        end else if (w_new_sample) begin
            r_prev_val  <= (w_addr1 == '0) ? w_scaled : r_cur_val;
            r_cur_val   <= w_scaled;
            r_held_addr <= w_addr1;
        end
    end

    assign w_lo  = (r_prev_val < r_cur_val) ? r_prev_val : r_cur_val;
    assign w_hi  = (r_prev_val < r_cur_val) ? r_cur_val  : r_prev_val;
    assign w_row = w_y2[SAMPLE_W:1];
    assign w_hit = w_region2 & (w_row >= w_lo) & (w_row <= w_hi);

`ifdef WAVE_DISPLAY_GRID_EN
    logic [5:0] w_x2_lo;

    wave_pipe_delay #(
        .WIDTH (6),
        .DEPTH (2)
    ) u_grid_x (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.x[5:0]),
        .o_q   (w_x2_lo)
    );

    always_comb begin
        w_rgb_next = 24'h000000;
        if (w_hit) begin
            w_rgb_next = TRACE_COLOR;
        end else if (w_region2 && ((w_x2_lo == 6'd0) || (w_y2[5:0] == 6'd0))) begin
            w_rgb_next = GRID_COLOR;
        end
    end
`else
    always_comb begin
        w_rgb_next = 24'h000000;
        if (w_hit) begin
            w_rgb_next = TRACE_COLOR;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_pixel <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_valid_pixel <= w_valid2;
            r_rgb         <= w_rgb_next;
        end
    end

    assign bus.wave_display_idle = r_idle;
    assign bus.valid_pixel       = r_valid_pixel;
    assign bus.r                 = r_rgb[23:16];
    assign bus.g                 = r_rgb[15:8];
    assign bus.b                 = r_rgb[7:0];

    // Bits with no role in the trace: the dropped sample LSB and row bits outside the scale.
    assign w_unused = ^{bus.read_value[0], w_y2[0], w_y2[Y_W-1]};

endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display: RAM model, 3-deep expectation queue, per-pixel checks.
`timescale 1ns/1ps
module tb_wave_display;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
`ifdef WAVE_DISPLAY_GRID_EN
    localparam logic [23:0] GRID_EXP = 24'h404040;
`else
    localparam logic [23:0] GRID_EXP = 24'h000000;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wave_display_if #(.X_W(11), .Y_W(10)) bus_if ();

    wave_display #(
        .X_W         (11),
        .Y_W         (10),
        .Y_OFFSET    (8'd32),
        .TRACE_COLOR (24'hFFFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [7:0] ram [512];

    always @(posedge clk) bus_if.read_value <= ram[bus_if.read_address];

    typedef struct {
        bit          chk;
        logic        vp;
        logic [23:0] rgb;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One pixel per call; outputs seen now belong to the pixel driven two calls earlier.
    task automatic drive(input int xx, input int yy, input bit vv, input bit chk,
                         input logic [23:0] rgb, input int idle, input int addr,
                         input string tag);
        exp_t e;
        bus_if.x     = xx[10:0];
        bus_if.y     = yy[9:0];
        bus_if.valid = vv;
        #1;
        if (addr >= 0)
            check_val({tag, "_addr"}, {23'd0, bus_if.read_address}, addr);
        @(posedge clk);
        @(negedge clk);
        if (idle >= 0)
            check_val({tag, "_idle"}, {31'd0, bus_if.wave_display_idle}, idle);
        e.chk = chk;
        e.vp  = vv;
        e.rgb = rgb;
        e.tag = tag;
        exp_q.push_back(e);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                $display("pixel %s vp=%0b rgb=%h", e.tag, bus_if.valid_pixel,
                         {bus_if.r, bus_if.g, bus_if.b});
                check_val({e.tag, "_vp"}, {31'd0, bus_if.valid_pixel}, {31'd0, e.vp});
                check_val({e.tag, "_rgb"}, {8'd0, bus_if.r, bus_if.g, bus_if.b}, {8'd0, e.rgb});
            end
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 1'b0, 1'b1, 24'h0, 1, -1, "blank");
    endtask

    initial begin
        int ys_ramp [6];
        int ys_start[4];
        logic [23:0] exp_start[4];

        for (int k = 0; k < 256; k++) begin
            ram[k]       = 8'h40;
            ram[256 + k] = 8'((2 * k) & 255);
        end
        bus_if.x          = '0;
        bus_if.y          = '0;
        bus_if.valid      = 1'b0;
        bus_if.read_index = 1'b0;

        // Reset state
        #12;
        check_val("rst_vp",   {31'd0, bus_if.valid_pixel}, 32'd0);
        check_val("rst_rgb",  {8'd0, bus_if.r, bus_if.g, bus_if.b}, 32'd0);
        check_val("rst_idle", {31'd0, bus_if.wave_display_idle}, 32'd0);
        check_val("rst_addr", {23'd0, bus_if.read_address}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle scan
        blank(10);

        // Flat trace in half 0: every sample scales to 64, row 128 hits, row 130 misses
        for (int x = 512; x < 1024; x++)
            drive(x, 128, 1'b1, 1'b1, WHITE, 0, -1, "flat128");
        blank(4);
        for (int x = 512; x < 1024; x++)
            drive(x, 130, 1'b1, 1'b1, (x % 64 == 0) ? GRID_EXP : 24'h0, 0, -1, "flat130");
        blank(4);

        // Frame lock
        bus_if.read_index = 1'b1;
        drive(0, 0, 1'b1, 1'b1, 24'h0, 1, 'h000, "lock00");
        drive(600, 0, 1'b1, 1'b1, GRID_EXP, 0, 'h12C, "lock600");
        bus_if.read_index = 1'b0;
        drive(600, 5, 1'b1, 1'b1, 24'h0, 0, 'h12C, "hold600");
        drive(600, 600, 1'b1, 1'b1, 24'h0, 1, 'h12C, "lowerhalf");
        drive(1100, 5, 1'b1, 1'b1, 24'h0, 1, 'h126, "xquad2");
        drive(511, 5, 1'b1, 1'b1, 24'h0, 1, 'h1FF, "x511");
        bus_if.read_index = 1'b1;
        blank(3);

        // Ramp in half 1: sample 5 spans rows 36..37 (y 72..75)
        ys_ramp = '{70, 72, 73, 74, 75, 76};
        foreach (ys_ramp[i]) begin
            drive(520, ys_ramp[i], 1'b1, 1'b0, 24'h0, -1, -1, "ramp_pre");
            drive(522, ys_ramp[i], 1'b1, 1'b1,
                  (ys_ramp[i] >= 72 && ys_ramp[i] <= 75) ? WHITE : 24'h0, 0, 'h105, "ramp522");
        end
        blank(3);

        // Row start: sample 255 (159) must not join sample 0 (32)
        ys_start  = '{64, 66, 200, 318};
        exp_start = '{WHITE, GRID_EXP, GRID_EXP, GRID_EXP};
        foreach (ys_start[i]) begin
            drive(1022, ys_start[i], 1'b1, 1'b0, 24'h0, -1, 'h1FF, "rowend");
            drive(512, ys_start[i], 1'b1, 1'b1, exp_start[i], 0, 'h100, "rowstart");
        end
        blank(3);

        // Grid line at x=576, y=100 with no trace
        drive(574, 100, 1'b1, 1'b0, 24'h0, -1, -1, "grid_pre");
        drive(576, 100, 1'b1, 1'b1, GRID_EXP, 0, 'h120, "grid576");
        blank(3);

        // Relock to half 0 at the next frame start
        bus_if.read_index = 1'b0;
        drive(0, 0, 1'b1, 1'b1, 24'h0, 1, 'h100, "relock00");
        drive(600, 0, 1'b1, 1'b1, GRID_EXP, 0, 'h02C, "relock600");
        blank(3);

        // Mid-frame reset: frame_index returns to 0, pipeline flushes
        bus_if.read_index = 1'b1;
        drive(0, 0, 1'b1, 1'b0, 24'h0, -1, -1, "mr00");
        drive(600, 0, 1'b1, 1'b0, 24'h0, -1, 'h12C, "mr600");
        reset = 1'b1;
        #1;
        check_val("mrst_vp",   {31'd0, bus_if.valid_pixel}, 32'd0);
        check_val("mrst_rgb",  {8'd0, bus_if.r, bus_if.g, bus_if.b}, 32'd0);
        check_val("mrst_idle", {31'd0, bus_if.wave_display_idle}, 32'd0);
        exp_q.delete();
        bus_if.valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        drive(600, 5, 1'b1, 1'b1, WHITE, 0, 'h02C, "postrst");
        blank(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wave_display.md
Name: wave_display

Overview:
- Reader side of the dual-half 512x8 sample RAM filled by the wave-capture block.
- Converts the VGA scan position into RAM read addresses, then draws the stored 256-sample waveform as a connected trace in one screen window.
- Outputs RGB per pixel and generates the wave_display_idle handshake that lets the capture side swap RAM halves.
- Sits between the VGA timing generator, the sample RAM read port, and the pixel mux.

Parameters:
X_W, 11, width of x coordinate
Y_W, 10, width of y coordinate
Y_OFFSET, 32, vertical offset added to scaled sample (8-bit)
TRACE_COLOR, 24'hFFFFFF, {r,g,b} of trace pixels

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
x  in  X_W  current pixel column
y  in  Y_W  current pixel row
valid  in  1  x/y are an on-screen pixel
read_index  in  1  RAM half the capture side designates for display
read_value  in  8  RAM read data (synchronous RAM, 1-cycle latency)
read_address  out  9  RAM read address
wave_display_idle  out  1  high when no trace pixels are being fetched
valid_pixel  out  1  r/g/b valid for a pixel
r  out  8  red
g  out  8  green
b  out  8  blue

Behaviour:
- All registers reset asynchronously on reset=1. Reset values:
  - frame_index=0, wave_display_idle=0, valid_pixel=0, r/g/b=0.
  - All pipeline registers 0.
- Window and addressing:
  - in_region = valid & (x[10:9]==2'b01) & (y[9]==0).
  - Each sample spans 2 columns: sample index = x[8:1].
  - read_address = {frame_index, x[8:1]}, combinational from inputs. It is driven regardless of in_region.
- Frame lock:
  - frame_index loads read_index on the cycle valid & x==0 & y==0.
  - Otherwise frame_index holds, so a read_index change mid-frame takes effect next frame.
- Stage 1 (registered): y1, valid1, region1, addr1=x[8:1]. read_value is valid this stage.
  - scaled = {1'b0, read_value[7:1]} + Y_OFFSET, 8-bit result with no overflow for the default offset.
- Stage 2 sample registers:
  - When region1 & (addr1 != held_addr | !region2): prev_val<=cur_val, cur_val<=scaled, held_addr<=addr1.
  - When addr1==0 (first sample of the row): prev_val<=scaled, so no line is drawn from the previous row.
  - y2, valid2, region2 registered from stage 1.
- Hit test (stage 2, combinational):
  - hit = region2 & (y2[8:1] >= min(prev_val,cur_val)) & (y2[8:1] <= max(prev_val,cur_val)).
  - Comparisons are inclusive and unsigned.
- Stage 3 outputs (registered):
  - valid_pixel<=valid2.
  - {r,g,b}<= hit ? TRACE_COLOR : 0.
- Latency: 3 clocks from x/y/valid to valid_pixel/rgb. Throughput is one pixel per clock with no stalls.
- wave_display_idle: registered, <= ~in_region (one-cycle delayed). It is high during blanking (valid=0), in other screen quadrants, and in the lower half.
- Mid-frame reset: pipeline flushes; frame_index=0 until the next (0,0) pixel.

Optional Feature:
- Macro: WAVE_DISPLAY_GRID_EN.
- When defined: in stage 3, non-hit pixels with region2 & (x2[5:0]==0 | y2[5:0]==0) output {r,g,b}=24'h404040. This requires x to also be pipelined to stage 2.
- When undefined: non-hit pixels are black, and the x pipeline beyond stage 1 is omitted.

Decomposition:
- Shared package (wave_pkg):
  - Region constants: REGION_X_SEL=2'b01.
  - Sample width 8, RAM address width 9, samples-per-half 256.
  - Default Y_OFFSET.
  - GRID_COLOR.
- One natural sub-module: wave_pipe_delay, a parameterised width/depth reset-to-zero delay line. It carries y/valid/region/x through stages 1-3.

Test Plan:
- Reset then idle scan: valid=0 for 10 cycles -> valid_pixel=0, rgb=0, wave_display_idle=1 from cycle 2.
- Frame lock: read_index=1, pixel (0,0) valid, then x=600 -> read_address=9'h100|(600[8:1]=44) = 9'h12C. Toggle read_index mid-frame -> address unchanged until next (0,0).
- Flat trace: RAM half 0 all 8'h40 (scaled 64); scan row y=128 (y[8:1]=64) across x=512..1023 -> rgb=FFFFFF on every valid_pixel, 3 cycles after each pixel. Row y=130 -> all black.
- Ramp segment: sample k=2k (scaled k+32); at x=522 (sample 5, scaled 37, prev 36) -> rows y=72..75 hit, y=70 and y=76 miss.
- Row start: sample 255=8'hFE, sample 0=8'h00 -> at x=512 only y[8:1]==32 hits (no vertical line from 159).
- Grid (WAVE_DISPLAY_GRID_EN): x=576, y=100, no hit -> rgb=404040. Without the macro -> rgb=0.
